// File: rtl/pacman_motion.sv
// Pacman game state: facing direction, sprite position and animation frame, updated once per video frame.
// Optional feature macro: PAC_WRAP_EN (edges wrap to the opposite side instead of blocking).
//
// state     | meaning
// S_IDLE    | no movement since reset, frame_select held at 0
// S_MOVE    | moving STEP pixels per move tick along direction, animating
// S_BLOCKED | clamped against an edge, waiting for a request pointing away from it
module pacman_motion #(
    parameter int unsigned SCALE       = 2,
    parameter int unsigned SPRITE_SIZE = 16,
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned STEP        = 2,
    parameter int unsigned MOVE_DIV    = 1,
    parameter int unsigned ANIM_DIV    = 5,
    parameter int unsigned START_X     = 304,
    parameter int unsigned START_Y     = 224
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_down,
    output logic [9:0] pac_x,
    output logic [9:0] pac_y,
    output logic [1:0] direction,
    output logic [1:0] frame_select,
    output logic       moving
);

`ifdef PAC_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    localparam int unsigned EXT = SPRITE_SIZE * SCALE;
    localparam logic [9:0] X_MAX  = 10'(H_RES - EXT);
    localparam logic [9:0] Y_MAX  = 10'(V_RES - EXT);
    localparam logic [9:0] STEP_V = 10'(STEP);
    localparam logic [9:0] X_LIM  = X_MAX - STEP_V;
    localparam logic [9:0] Y_LIM  = Y_MAX - STEP_V;
    localparam logic [3:0] MDIV_LAST = 4'(MOVE_DIV - 1);
    localparam logic [3:0] ADIV_LAST = 4'(ANIM_DIV - 1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MOVE    = 2'd1;
    localparam logic [1:0] S_BLOCKED = 2'd2;

    logic [1:0] state;
    logic [1:0] req_dir;
    logic       req_valid;
    logic [1:0] blk_dir;
    logic [3:0] mdiv;
    logic [3:0] adiv;

    logic       btn_any;
    logic [1:0] btn_dir;
    logic       take_valid;
    logic [1:0] take_dir;
    logic [1:0] new_dir;
    logic       move_tick;
    logic       anim_roll;
    logic       go;
    logic       hit;
    logic [9:0] nx;
    logic [9:0] ny;

    // A press in the frame_tick cycle counts for that tick, so merge live buttons with the latch.
    always_comb begin
        btn_any    = btn_up | btn_left | btn_right | btn_down;
        btn_dir    = btn_up ? DIR_UP : btn_left ? DIR_LEFT : btn_right ? DIR_RIGHT : DIR_DOWN;
        take_valid = btn_any | req_valid;
        take_dir   = btn_any ? btn_dir : req_dir;
        new_dir    = take_valid ? take_dir : direction;
        move_tick  = (mdiv == MDIV_LAST);
        anim_roll  = (adiv == ADIV_LAST);
        go         = (state == S_MOVE)
                   | ((state == S_IDLE) & take_valid)
                   | ((state == S_BLOCKED) & take_valid & (take_dir != blk_dir));
    end

    // Edge tests come before the add/subtract so no intermediate ever goes negative or past MAX.
    always_comb begin
        nx  = pac_x;
        ny  = pac_y;
        hit = 1'b0;
        case (new_dir)
            DIR_UP: begin
                if (pac_y < STEP_V) begin
                    hit = 1'b1;
                    ny  = WRAP ? Y_MAX : 10'd0;
                end else begin
                    ny = pac_y - STEP_V;
                end
            end
            DIR_RIGHT: begin
                if (pac_x > X_LIM) begin
                    hit = 1'b1;
                    nx  = WRAP ? 10'd0 : X_MAX;
                end else begin
                    nx = pac_x + STEP_V;
                end
            end
            DIR_LEFT: begin
                if (pac_x < STEP_V) begin
                    hit = 1'b1;
                    nx  = WRAP ? X_MAX : 10'd0;
                end else begin
                    nx = pac_x - STEP_V;
                end
            end
            default: begin
                if (pac_y > Y_LIM) begin
                    hit = 1'b1;
                    ny  = WRAP ? 10'd0 : Y_MAX;
                end else begin
                    ny = pac_y + STEP_V;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pac_x        <= 10'(START_X);
            pac_y        <= 10'(START_Y);
            direction    <= DIR_RIGHT;
            frame_select <= 2'd0;
            state        <= S_IDLE;
            req_dir      <= DIR_UP;
            req_valid    <= 1'b0;
            blk_dir      <= DIR_UP;
            mdiv         <= 4'd0;
            adiv         <= 4'd0;
        end else begin
            if (frame_tick) begin
                req_valid <= 1'b0;
            end else if (btn_any) begin
                req_valid <= 1'b1;
                req_dir   <= btn_dir;
            end

            if (frame_tick) begin
                direction <= new_dir;
                mdiv      <= move_tick ? 4'd0 : mdiv + 4'd1;
                if (go) begin
                    state <= S_MOVE;
                    if (move_tick) begin
                        pac_x <= nx;
                        pac_y <= ny;
                        if (hit && !WRAP) begin
                            state        <= S_BLOCKED;
                            blk_dir      <= new_dir;
                            frame_select <= 2'd0;
                            adiv         <= 4'd0;
                        end else if (anim_roll) begin
                            adiv         <= 4'd0;
                            frame_select <= frame_select + 2'd1;
                        end else begin
                            adiv <= adiv + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign moving = (state == S_MOVE);

endmodule

// File: tb/tb_pacman_motion.sv
// Self-checking bench for pacman_motion at default parameters; expectations follow PAC_WRAP_EN when defined.
module tb_pacman_motion;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_up = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0;
    logic [9:0] pac_x, pac_y;
    logic [1:0] direction, frame_select;
    logic       moving;

    int checks = 0;
    int errors = 0;

    pacman_motion dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down),
        .pac_x(pac_x), .pac_y(pac_y), .direction(direction),
        .frame_select(frame_select), .moving(moving)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] dir;
        logic [1:0] fs;
        logic       mv;
    } exp_t;

    // btn fields: [3]=up [2]=left [1]=right [0]=down
    typedef struct {
        logic [3:0] pre;
        logic [3:0] on_tick;
        int         ticks;
        exp_t       e;
    } vec_t;

    vec_t vecs[12];
    exp_t sb[$];

    task automatic set_btn(input logic [3:0] b);
        btn_up    = b[3];
        btn_left  = b[2];
        btn_right = b[1];
        btn_down  = b[0];
    endtask

    task automatic press(input logic [3:0] b);
        @(negedge clk);
        set_btn(b);
        @(negedge clk);
        set_btn(4'b0000);
    endtask

    task automatic tick(input logic [3:0] b);
        @(negedge clk);
        set_btn(b);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        set_btn(4'b0000);
    endtask

    task automatic push_exp(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d,
                            input logic [1:0] fs, input logic mv);
        exp_t e;
        e.x = x; e.y = y; e.dir = d; e.fs = fs; e.mv = mv;
        sb.push_back(e);
    endtask

    task automatic check_out(input string name);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            if (pac_x !== e.x || pac_y !== e.y || direction !== e.dir ||
                frame_select !== e.fs || moving !== e.mv) begin
                errors++;
                $display("FAIL %s: got x=%0d y=%0d dir=%0d fs=%0d mv=%0b, expected x=%0d y=%0d dir=%0d fs=%0d mv=%0b",
                         name, pac_x, pac_y, direction, frame_select, moving,
                         e.x, e.y, e.dir, e.fs, e.mv);
            end
        end
    endtask

    task automatic run_vec(input int i);
        if (vecs[i].pre != 4'b0000) press(vecs[i].pre);
        sb.push_back(vecs[i].e);
        for (int t = 0; t < vecs[i].ticks; t++) begin
            tick((t == 0) ? vecs[i].on_tick : 4'b0000);
        end
        check_out($sformatf("vec%0d", i));
    endtask

    function automatic vec_t mk(input logic [3:0] pre, input logic [3:0] on_tick, input int ticks,
                                input logic [9:0] x, input logic [9:0] y, input logic [1:0] d,
                                input logic [1:0] fs, input logic mv);
        vec_t v;
        v.pre = pre; v.on_tick = on_tick; v.ticks = ticks;
        v.e.x = x; v.e.y = y; v.e.dir = d; v.e.fs = fs; v.e.mv = mv;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // frame_select follows k = total move ticks: fs = (k/5)%4
        vecs[0]  = mk(4'b0010, 4'b0000,   6, 10'd316, 10'd224, 2'd1, 2'd1, 1'b1);
        vecs[1]  = mk(4'b1001, 4'b0000,   1, 10'd316, 10'd222, 2'd0, 2'd1, 1'b1);
        vecs[2]  = mk(4'b0100, 4'b0000,   3, 10'd310, 10'd222, 2'd2, 2'd2, 1'b1);
        vecs[3]  = mk(4'b0001, 4'b0000,   5, 10'd310, 10'd232, 2'd3, 2'd3, 1'b1);
        vecs[4]  = mk(4'b0110, 4'b0000,   5, 10'd300, 10'd232, 2'd2, 2'd0, 1'b1);
        vecs[5]  = mk(4'b0000, 4'b0000,   1, 10'd298, 10'd232, 2'd2, 2'd0, 1'b1);
        vecs[6]  = mk(4'b0011, 4'b0000,   2, 10'd302, 10'd232, 2'd1, 2'd0, 1'b1);
        vecs[7]  = mk(4'b0000, 4'b0100,   1, 10'd300, 10'd234, 2'd2, 2'd1, 1'b1);
        vecs[8]  = mk(4'b0000, 4'b0000, 150, 10'd0,   10'd234, 2'd2, 2'd3, 1'b1);
`ifdef PAC_WRAP_EN
        vecs[9]  = mk(4'b0000, 4'b0000,   1, 10'd608, 10'd234, 2'd2, 2'd3, 1'b1);
        vecs[10] = mk(4'b0000, 4'b0100,   1, 10'd606, 10'd234, 2'd2, 2'd3, 1'b1);
        vecs[11] = mk(4'b0000, 4'b0010,   1, 10'd608, 10'd234, 2'd1, 2'd3, 1'b1);
`else
        vecs[9]  = mk(4'b0000, 4'b0000,   1, 10'd0,   10'd234, 2'd2, 2'd0, 1'b0);
        vecs[10] = mk(4'b0000, 4'b0100,   1, 10'd0,   10'd234, 2'd2, 2'd0, 1'b0);
        vecs[11] = mk(4'b0000, 4'b0010,   1, 10'd2,   10'd234, 2'd1, 2'd0, 1'b1);
`endif

        set_btn(4'b0000);
        repeat (3) @(negedge clk);
        push_exp(10'd304, 10'd224, 2'd1, 2'd0, 1'b0);
        check_out("reset");
        rst_n = 1'b1;

        // Presses without frame_tick only latch a request; outputs must hold.
        set_btn(4'b1000);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            push_exp(10'd304, 10'd224, 2'd1, 2'd0, 1'b0);
            check_out($sformatf("hold%0d", c));
        end
        set_btn(4'b0000);

        // The latched up is overwritten by vec0's later right press.
        for (int i = 0; i < 7; i++) run_vec(i);

        // Later press overwrites earlier capture: up then down, one tick.
        press(4'b1000);
        press(4'b0001);
        push_exp(10'd302, 10'd234, 2'd3, 2'd0, 1'b1);
        tick(4'b0000);
        check_out("overwrite");

        for (int i = 7; i < 12; i++) run_vec(i);

        // Asynchronous reset in the middle of a cycle.
        @(negedge clk);
        #7;
        rst_n = 1'b0;
        #1;
        push_exp(10'd304, 10'd224, 2'd1, 2'd0, 1'b0);
        check_out("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
